smem_issue_scheduler: RTL

SMEM_ISSUE_SCHEDULER -- requirements
Module: smem_issue_scheduler

---
 rtl/smem_pkg.sv | 22 ++
 rtl/smem_inflight_cnt.sv | 43 ++++
 rtl/smem_issue_scheduler.sv | 131 +++++++++++++
 3 files changed

// File: rtl/smem_pkg.sv
// Shared types and encodings for the shared-memory issue scheduler.
package smem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [1:0] SEL_BUBBLE = 2'b00;
  localparam logic [1:0] SEL_RECIRC = 2'b01;
  localparam logic [1:0] SEL_NEW    = 2'b10;

  localparam logic [5:0] BUBBLE = 6'b110000;

  function automatic logic is_issuing(state_e s);
    return (s == S_RUN) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/smem_inflight_cnt.sv
// Resident-read up/down counter; a decrement at zero saturates and raises a sticky error.
module smem_inflight_cnt #(
  parameter int W = 9
) (
  input  logic         Clk_32UI,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         err_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i) begin
      if (cnt_q == '0) err_d = 1'b1;
      else             cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge Clk_32UI) begin
    if (!reset_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = err_q;

endmodule

// File: rtl/smem_issue_scheduler.sv
// Batch issue scheduler: recirculates memory responses ahead of new-read injection.
// Optional bubble performance counter enabled by SMEM_SCHED_PERF_EN.
module smem_issue_scheduler
  import smem_pkg::*;
#(
  parameter int MAX_INFLIGHT = 256
) (
  input  logic        Clk_32UI,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        start,
  input  logic [9:0]  total_reads,
  input  logic        load_done,
  input  logic        mem_resp_valid,
  output logic        mem_resp_pop,
  input  logic        new_read_valid,
  output logic        new_read,
  input  logic        read_retire,
  output logic [1:0]  issue_sel,
  output logic [8:0]  inflight,
  output logic        busy,
  output logic        batch_done,
  output logic        err_underflow,
  output logic [31:0] perf_bubble_cnt
);

  localparam logic [8:0] MAX_Q = 9'(MAX_INFLIGHT);

  state_e     state_q, state_d;
  logic [9:0] total_q, total_d;
  logic [9:0] inj_q, inj_d;
  logic [1:0] sel_q, sel_d;
  logic       start_acc;
  logic       can_inject;

  assign start_acc  = (state_q == S_IDLE) && start;
  assign can_inject = (inj_q < total_q) && (inflight < MAX_Q);

  always_comb begin
    state_d      = state_q;
    total_d      = total_q;
    inj_d        = inj_q;
    mem_resp_pop = 1'b0;
    new_read     = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        total_d = total_reads;
        inj_d   = '0;
        state_d = S_WAIT_LOAD;
      end
      S_WAIT_LOAD: if (load_done) state_d = S_RUN;
      S_RUN: begin
        if (!stall) begin
          if (mem_resp_valid) begin
            mem_resp_pop = 1'b1;
          end else if (new_read_valid && can_inject) begin
            new_read = 1'b1;
            inj_d    = inj_q + 10'd1;
          end
        end
        if (inj_q == total_q) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!stall && mem_resp_valid) mem_resp_pop = 1'b1;
        if (inflight == '0 && !mem_resp_valid) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Slot type lands one cycle after the decision; forced to bubble once issuing ends.
  always_comb begin
    sel_d = SEL_BUBBLE;
    if (is_issuing(state_q) && is_issuing(state_d)) begin
      if (stall)             sel_d = sel_q;
      else if (mem_resp_pop) sel_d = SEL_RECIRC;
      else if (new_read)     sel_d = SEL_NEW;
    end
  end

  always_ff @(posedge Clk_32UI) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      total_q <= '0;
      inj_q   <= '0;
      sel_q   <= SEL_BUBBLE;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      inj_q   <= inj_d;
      sel_q   <= sel_d;
    end
  end

  smem_inflight_cnt #(.W(9)) u_inflight (
    .Clk_32UI (Clk_32UI),
    .reset_n  (reset_n),
    .clr_i    (start_acc),
    .inc_i    (new_read),
    .dec_i    (read_retire),
    .cnt_o    (inflight),
    .err_o    (err_underflow)
  );

`ifdef SMEM_SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (start_acc)
      perf_d = '0;
    else if (state_q == S_RUN && !stall && !mem_resp_pop && !new_read && perf_q != 32'hFFFF_FFFF)
      perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge Clk_32UI) begin
    if (!reset_n) perf_q <= '0;
    else          perf_q <= perf_d;
  end

  assign perf_bubble_cnt = perf_q;
`else
  assign perf_bubble_cnt = '0;
`endif

  assign issue_sel  = sel_q;
  assign busy       = (state_q != S_IDLE);
  assign batch_done = (state_q == S_DONE);

endmodule
